// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter (8E1 with UART_TX_PARITY_EN).
// Ports: CLK_100MHZ, RESET (async high), in_data/in_valid/in_ready, TX, busy.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       CLK_100MHZ,
  input  logic       RESET,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       TX,
  output logic       busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shf_q, shf_d;
  logic          tx_q, tx_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]    mem_q [DEPTH];

  logic full, empty, push, pop, bit_end;
  logic [7:0] head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2])
              && (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign push  = in_valid && !full;
  assign head  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign bit_end = (cnt_q == CNT_LAST);

  assign in_ready = !full;
  assign TX       = tx_q;
  assign busy     = (state_q != S_IDLE) || !empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shf_d   = shf_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    // baud counter runs in every non-idle state, restarting per bit
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shf_d   = head;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = shf_q[0];
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = ^shf_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shf_q[idx_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          // chain the next frame directly: no idle gap
          if (!empty) begin
            pop     = 1'b1;
            shf_d   = head;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK_100MHZ or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shf_q    <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shf_q   <= shf_d;
      tx_q    <= tx_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // storage needs no reset: pointers define validity
  always_ff @(posedge CLK_100MHZ) begin
    if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench for uart_tx_fifo against a frame-level
// model (byte queue plus position-in-frame arithmetic).
module tb_uart_tx_fifo;

  localparam int N     = 4;
  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = (PAR ? 11 : 10) * N;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       vld = 1'b0;
  logic       rdy, tx, busy;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT(N),
    .DEPTH_LOG2  (DL)
  ) dut (
    .CLK_100MHZ(clk),
    .RESET     (rst),
    .in_data   (din),
    .in_valid  (vld),
    .in_ready  (rdy),
    .TX        (tx),
    .busy      (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] q[$];
  bit         act = 1'b0;
  int         pos = 0;
  logic [7:0] cur = 8'h00;
  int         n_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!act) return 1'b1;
    k = pos / N;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    if (PAR && k == 9) return ^cur;
    return 1'b1;
  endfunction

  task automatic compare();
    chk("tx", 32'(tx), 32'(exp_tx()));
    chk("in_ready", 32'(rdy), 32'(q.size() < DEPTH));
    chk("busy", 32'(busy), 32'(act || q.size() != 0));
  endtask

  task automatic model_edge();
    bit push, pop;
    if (rst) begin
      q.delete();
      act = 1'b0;
      pos = 0;
      return;
    end
    push = vld && (q.size() < DEPTH);
    pop  = (q.size() > 0) && (!act || pos == FRAME - 1);
    if (pop) begin
      cur = q.pop_front();
      act = 1'b1;
      pos = 0;
    end else if (act) begin
      pos++;
      if (pos == FRAME) act = 1'b0;
    end
    if (push) begin
      q.push_back(din);
      n_acc++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    vld = 1'b1;
    din = b;
    step();
    vld = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    vld = 1'b0;
    while ((act || q.size() != 0) && g < 5000) begin
      step();
      g++;
    end
    chk("drain_bound", 32'(g < 5000), 32'd1);
    idle(3);
  endtask

  task automatic reset_at(input int p);
    int g = 0;
    while (!(act && pos == p) && g < 500) begin
      step();
      g++;
    end
    chk("rst_wait_bound", 32'(g < 500), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_tx", 32'(tx), 32'd1);
    chk("rst_async_rdy", 32'(rdy), 32'd1);
    chk("rst_async_busy", 32'(busy), 32'd0);
    q.delete();
    act = 1'b0;
    pos = 0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    compare();
    step();
    rst = 1'b0;
    idle(3);

    send(8'h55);
    drain();

    vld = 1'b1;
    din = 8'hA5; step();
    din = 8'h00; step();
    din = 8'hFF; step();
    vld = 1'b0;
    drain();

    vld = 1'b1;
    din = 8'h10;
    for (int i = 0; i < 60; i++) begin
      step();
      din = din + 8'd1;
    end
    vld = 1'b0;
    drain();

    send(8'h3C);
    send(8'hF0);
    reset_at(4 * N + 1);
    idle(2);
    send(8'h81);
    drain();

    send(8'h00);
    reset_at(3 * N + 2);
    idle(2);

    send(8'h07);
    drain();
    send(8'h03);
    drain();

    n_acc = 0;
    for (int i = 0; i < 2500; i++) begin
      vld = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      step();
    end
    vld = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-stream UART transmitter driving the board's serial line back to the host (FPGA TX pin to the FTDI RX input). It accepts result bytes from the solver core over a valid/ready handshake, buffers them in a small FIFO, and serialises them LSB-first as 8N1 frames, or 8E1 with the parity option. It sits in the 100 MHz domain next to the UART receiver and completes the host link.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clock cycles per bit (100 MHz / 115200 baud); must be ≥ 2.
- DEPTH_LOG2, default 4: FIFO depth is 2^DEPTH_LOG2 bytes; must be ≥ 1.

Ports:
- CLK_100MHZ  input  1  system clock; all logic on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- in_data  input  8  byte to transmit.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a byte; equals !full; reset 1.
- TX  output  1  serial line, idle high, registered; reset 1.
- busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty; reset 0.

## Operation
- Write: a byte is pushed on a rising edge where in_valid && in_ready. in_data is ignored otherwise.
- in_ready depends only on the FIFO count. A pop in the same cycle does not allow a write into a full FIFO.
- Pointers are DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1).
  - full: pointers differ only in the MSB.
  - empty: pointers equal.
  - Simultaneous push and pop leave the count unchanged.
- FSM states: IDLE, START, DATA, PARITY (only with the parity option), STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register, TX<=0, go to START. Otherwise TX stays 1.
  - START: after CLKS_PER_BIT cycles, TX<=bit0, bit index<=0, go to DATA.
  - DATA: every CLKS_PER_BIT cycles, shift out the next bit, LSB first. After bit7 completes, go to PARITY (TX<=parity) or STOP (TX<=1).
  - PARITY: after CLKS_PER_BIT cycles, TX<=1, go to STOP.
  - STOP: after CLKS_PER_BIT cycles:
    - FIFO non-empty: pop, TX<=0, go to START (back-to-back; no extra idle).
    - FIFO empty: go to IDLE.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, reloads 0 at every bit boundary, and is held at 0 in IDLE.
- Reset, including mid-frame: TX=1, FSM=IDLE, FIFO emptied, counters cleared. A partial frame is abandoned and never resumed.

## Timing
- Latency: a byte written to an empty FIFO with the FSM in IDLE drives TX low on the first rising edge after the accepting edge.
- Every bit, including start, parity and stop, lasts exactly CLKS_PER_BIT cycles.
- Frame length is 10×CLKS_PER_BIT cycles (11× with parity).
- Throughput with the FIFO continuously non-empty: one byte per frame, with no gap cycles between frames.
- busy falls on the same edge on which the STOP→IDLE transition occurs with the FIFO empty.
- No combinational path from in_valid to in_ready or to TX.

## Configuration
- Macro UART_TX_PARITY_EN.
  - Defined: PARITY state compiled in; frames are 8E1. The parity bit is the XOR of the 8 data bits, so the total count of ones in data plus parity is even.
  - Undefined: no PARITY state; DATA goes directly to STOP; frames are 8N1.

## Test plan
- Single byte, CLKS_PER_BIT=4, 8N1: write 0x55 at edge E0 → TX low from E1 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high for 4 cycles. busy drops after 40 cycles of frame.
- Back-to-back: write 0xA5, 0x00, 0xFF on consecutive cycles → three contiguous 40-cycle frames with no idle gap; bits match LSB-first.
- Back-pressure, DEPTH_LOG2=2: hold in_valid high with incrementing data → 5 bytes accepted (4 in FIFO plus 1 in the shifter), then in_ready=0. in_ready returns to 1 on the edge after the next pop. All bytes arrive in order.
- Reset mid-frame: assert RESET during DATA bit 3 of 0x3C → TX=1 immediately (asynchronous), in_ready=1, busy=0. A new write of 0x81 after release produces a clean frame.
- Parity (UART_TX_PARITY_EN defined): 0x07 → parity bit 1; 0x03 → parity bit 0. Frame is 44 cycles at CLKS_PER_BIT=4.
- Pointer wrap: stream 40 bytes through DEPTH_LOG2=2 → received sequence identical to the sent sequence, with no loss or duplication.
